// File: rtl/go_arb_pkg.sv
// Shared constants and state encoding for the go/kill/done engine arbiter.
package go_arb_pkg;

   localparam int unsigned N_REQ_DEF   = 3;
   localparam int unsigned TIMEOUT_DEF = 255;
   localparam int unsigned TO_W_DEF    = 8;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t GO   = 2'd1;
   localparam state_t WAIT = 2'd2;
   localparam state_t KILL = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo N_REQ.
module rr_pick #(
   parameter int unsigned N_REQ = 3,
   localparam int unsigned IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] pick,
   output logic [IW-1:0]    pick_idx
);

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      pick     = '0;
      pick_idx = '0;
      found    = 1'b0;
      idx      = '0;
      for (int k = 0; k < int'(N_REQ); k++) begin
         idx = IW'((32'(ptr) + 32'(k)) % N_REQ);
         if (!found && req[idx]) begin
            found     = 1'b1;
            pick[idx] = 1'b1;
            pick_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/go_arbiter.sv
// Round-robin owner of a single go/kill/done delay engine shared by N_REQ requesters.
// Define GO_ARB_TIMEOUT_EN to add the WAIT-state timer that forces a kill.
module go_arbiter
   import go_arb_pkg::*;
#(
   parameter int unsigned N_REQ   = N_REQ_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned TO_W    = TO_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] abort,
   input  logic             kill_clr,
   input  logic             eng_done,
   output logic             eng_go,
   output logic             eng_kill,
   output logic [N_REQ-1:0] grant,
   output logic             busy,
   output logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] err,
   output logic             kill_ltchd
);

   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic             kill_q, kill_d;
   logic [N_REQ-1:0] pick;
   logic [IW-1:0]    pick_idx;
   logic             abort_hit;
   logic             timeout_hit;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req      (req),
      .ptr      (ptr_q),
      .pick     (pick),
      .pick_idx (pick_idx)
   );

   // Abort bits of requesters that do not own the engine are ignored.
   assign abort_hit = |(abort & grant_q);

`ifdef GO_ARB_TIMEOUT_EN
   logic [TO_W-1:0] timer_q, timer_d;

   // Zero during GO, so in WAIT the timer equals cycles since eng_go.
   always_comb begin
      timer_d = '0;
      if (state_q == GO || state_q == WAIT) begin
         timer_d = timer_q + 1'b1;
      end
   end

   assign timeout_hit = (state_q == WAIT) && (timer_q >= TO_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`else
   // Timer parameters stay on the interface so both builds share one instantiation.
   logic [TO_W-1:0] unused_timeout;
   assign unused_timeout = TO_W'(TIMEOUT);
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d = pick;
               ptr_d   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
               state_d = GO;
            end
         end
         GO: begin
            state_d = WAIT;
         end
         WAIT: begin
            // Completion beats a same-cycle abort or timeout.
            if (eng_done) begin
               grant_d = '0;
               state_d = IDLE;
            end else if (abort_hit || timeout_hit) begin
               state_d = KILL;
            end
         end
         KILL: begin
            grant_d = '0;
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      kill_d = kill_q;
      if (state_q == KILL) begin
         kill_d = 1'b1;
      end else if (kill_clr) begin
         kill_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         kill_q  <= kill_d;
      end
   end

   assign eng_go     = (state_q == GO);
   assign eng_kill   = (state_q == KILL);
   assign busy       = (state_q != IDLE);
   assign grant      = grant_q;
   assign done       = (state_q == WAIT && eng_done) ? grant_q : '0;
   assign err        = (state_q == KILL) ? grant_q : '0;
   assign kill_ltchd = kill_q;

endmodule

// File: tb/tb_go_arbiter.sv
// Directed bench for go_arbiter with a transaction-level reference model checked every cycle.
module tb_go_arbiter;

   localparam int NR = 3;
   localparam int TO = 8;
`ifdef GO_ARB_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NR-1:0] req = '0;
   logic [NR-1:0] abort = '0;
   logic          kill_clr = 1'b0;
   logic          eng_done = 1'b0;
   logic          eng_go;
   logic          eng_kill;
   logic [NR-1:0] grant;
   logic          busy;
   logic [NR-1:0] done;
   logic [NR-1:0] err;
   logic          kill_ltchd;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   go_arbiter #(
      .N_REQ   (NR),
      .TIMEOUT (TO),
      .TO_W    (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .abort      (abort),
      .kill_clr   (kill_clr),
      .eng_done   (eng_done),
      .eng_go     (eng_go),
      .eng_kill   (eng_kill),
      .grant      (grant),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .kill_ltchd (kill_ltchd)
   );

   function void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference model: phase 0 idle, 1 go issued, 2 engine running, 3 killing.
   int ph = 0;
   int own = 0;
   int mptr = 0;
   int since = 0;
   bit kl = 1'b0;
   bit armed = 1'b0;

   always @(posedge clk) begin : model_upd
      int nph, nown, nptr, nsince;
      bit nkl;
      if (reset) begin
         ph    <= 0;
         own   <= 0;
         mptr  <= 0;
         since <= 0;
         kl    <= 1'b0;
         armed <= 1'b1;
      end else begin
         nph    = ph;
         nown   = own;
         nptr   = mptr;
         nsince = since;
         nkl    = kl;
         if (ph == 3) nkl = 1'b1;
         else if (kill_clr) nkl = 1'b0;
         case (ph)
            0: if (req != '0) begin
               // Scan downward so the smallest offset from the pointer wins.
               for (int k = NR - 1; k >= 0; k--) begin
                  if (((req >> ((mptr + k) % NR)) & 3'b001) != 3'b000) nown = (mptr + k) % NR;
               end
               nptr = (nown + 1) % NR;
               nph  = 1;
            end
            1: begin
               nph    = 2;
               nsince = 1;
            end
            2: begin
               if (eng_done) nph = 0;
               else if (((abort >> own) & 3'b001) != 3'b000 || (TO_ON && since + 1 >= TO)) nph = 3;
               nsince = since + 1;
            end
            default: nph = 0;
         endcase
         ph    <= nph;
         own   <= nown;
         mptr  <= nptr;
         since <= nsince;
         kl    <= nkl;
      end
   end

   always @(negedge clk) begin : compare
      logic [12:0] act, exp;
      logic [NR-1:0] g;
      if (armed) begin
         g   = (ph != 0) ? NR'(1 << own) : '0;
         exp = {ph == 1, ph == 3, ph != 0, kl, g,
                (ph == 2 && eng_done) ? g : 3'b000, (ph == 3) ? g : 3'b000};
         act = {eng_go, eng_kill, busy, kill_ltchd, grant, done, err};
         check("cycle", 32'(act), 32'(exp));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns on the negedge of the GO cycle; n counts negedges taken.
   task automatic wait_go(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!eng_go && n < 20);
      check("go_seen", 32'(eng_go), 32'd1);
   endtask

   logic [NR-1:0] order [4];
   logic [NR-1:0] exp_order [4];
   int n;

   initial begin
      exp_order[0] = 3'b001;
      exp_order[1] = 3'b010;
      exp_order[2] = 3'b100;
      exp_order[3] = 3'b001;

      step(2);
      reset = 1'b0;
      @(negedge clk);
      check("reset_outs", 32'({eng_go, eng_kill, busy, kill_ltchd, grant, done, err}), 32'd0);

      // Single request: go two cycles after req, done in the fifth WAIT cycle.
      step(1);
      req = 3'b010;
      wait_go(n);
      check("go_latency", n, 32'd2);
      check("single_grant", 32'(grant), 32'b010);
      step(1);
      step(4);
      eng_done = 1'b1;
      @(negedge clk);
      check("single_done", 32'(done), 32'b010);
      step(1);
      eng_done = 1'b0;
      req = 3'b000;
      @(negedge clk);
      check("single_idle", 32'({busy, grant}), 32'd0);

      // Round robin from a fresh pointer.
      step(1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      req = 3'b111;
      for (int i = 0; i < 4; i++) begin
         wait_go(n);
         check("rr_gap", n, 32'd2);
         order[i] = grant;
         step(1);
         step(2);
         eng_done = 1'b1;
         step(1);
         eng_done = 1'b0;
         if (i == 3) req = 3'b000;
      end
      for (int i = 0; i < 4; i++) check("rr_order", 32'(order[i]), 32'(exp_order[i]));

      // Abort from a non-owner is ignored; owner abort kills with kill_clr colliding.
      step(1);
      req = 3'b100;
      wait_go(n);
      step(1);
      abort = 3'b010;
      step(2);
      check("foreign_abort", 32'({busy, eng_kill, grant}), 32'b1_0_100);
      step(1);
      abort = 3'b100;
      step(1);
      abort = 3'b000;
      kill_clr = 1'b1;
      @(negedge clk);
      check("abort_kill", 32'({eng_kill, err}), 32'b1_100);
      step(1);
      kill_clr = 1'b0;
      req = 3'b000;
      @(negedge clk);
      check("kill_clr_collision", 32'(kill_ltchd), 32'd1);
      step(1);
      kill_clr = 1'b1;
      step(1);
      kill_clr = 1'b0;
      @(negedge clk);
      check("kill_clr", 32'(kill_ltchd), 32'd0);

      // eng_done and owner abort together: done only.
      step(1);
      req = 3'b001;
      wait_go(n);
      step(1);
      eng_done = 1'b1;
      abort = 3'b001;
      @(negedge clk);
      check("collide_done", 32'({done, err}), 32'b001_000);
      step(1);
      eng_done = 1'b0;
      abort = 3'b000;
      req = 3'b000;
      @(negedge clk);
      check("collide_nokill", 32'({eng_kill, busy, kill_ltchd}), 32'd0);

      // Abort present only during GO is never sampled.
      step(1);
      req = 3'b010;
      wait_go(n);
      abort = 3'b010;
      step(1);
      abort = 3'b000;
      @(negedge clk);
      check("go_abort_w1", 32'({busy, eng_kill}), 32'b10);
      step(1);
      @(negedge clk);
      check("go_abort_w2", 32'({busy, eng_kill, grant}), 32'b1_0_010);
      eng_done = 1'b1;
      step(1);
      eng_done = 1'b0;
      req = 3'b000;

`ifdef GO_ARB_TIMEOUT_EN
      // Timeout: engine silent, kill exactly TO cycles after go.
      step(1);
      req = 3'b001;
      wait_go(n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!eng_kill && n < 40);
      check("timeout_delay", n, 32'(TO));
      check("timeout_err", 32'(err), 32'b001);
      step(1);
      req = 3'b000;
      step(3);
      @(negedge clk);
      check("timeout_latch", 32'(kill_ltchd), 32'd1);
      step(1);
      kill_clr = 1'b1;
      step(1);
      kill_clr = 1'b0;
      @(negedge clk);
      check("timeout_clr", 32'(kill_ltchd), 32'd0);
`endif

      // Reset in mid-WAIT: quiet outputs, no kill, next grant goes to index 0.
      step(1);
      req = 3'b001;
      wait_go(n);
      step(2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      @(negedge clk);
      check("reset_wait", 32'({eng_go, eng_kill, busy, kill_ltchd, grant, done, err}), 32'd0);
      wait_go(n);
      check("reset_regrant", 32'(grant), 32'b001);
      step(1);
      eng_done = 1'b1;
      step(1);
      eng_done = 1'b0;
      req = 3'b000;
      step(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench still running at t=%0t, expected to have finished", $time);
      $fatal(1);
   end

endmodule
